fu_issue: RTL and testbench

FU_ISSUE -- requirements
Module: fu_issue

---
 rtl/fu_issue_if.sv | 60 ++++++
 rtl/fu_issue.sv | 148 ++++++++++++++
 tb/tb_fu_issue.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_issue_if.sv
// Shared payload type, unit-count macros and the issue-stage bus interface.
// Slave modport is the fu_issue side; master is the dispatch/FU environment.
`ifndef N
`define N 2
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 2
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 1
`endif
`ifndef NUM_FU_LOAD
`define NUM_FU_LOAD 1
`endif
`ifndef NUM_FU_STORE
`define NUM_FU_STORE 1
`endif

package fu_issue_pkg;
    typedef struct packed {
        logic       valid;
        logic [7:0] tag;
    } fu_packet_t;
endpackage

interface fu_issue_if
    import fu_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    fu_packet_t                    in_packet      [`N];
    logic [1:0]                    in_class       [`N];
    logic                          in_ready;
    logic                          squash;
    logic [`NUM_FU_ALU-1:0]        alu_avail;
    logic [`NUM_FU_MULT-1:0]       mult_avail;
    logic [`NUM_FU_LOAD-1:0]       load_avail;
    logic [`NUM_FU_STORE-1:0]      store_avail;
    fu_packet_t                    fu_alu_packet  [`NUM_FU_ALU];
    fu_packet_t                    fu_mult_packet [`NUM_FU_MULT];
    fu_packet_t                    fu_load_packet [`NUM_FU_LOAD];
    fu_packet_t                    fu_store_packet[`NUM_FU_STORE];
    logic [OW-1:0]                 occupancy      [4];

    modport slave (
        input  in_packet, in_class, squash,
        input  alu_avail, mult_avail, load_avail, store_avail,
        output in_ready, occupancy,
        output fu_alu_packet, fu_mult_packet, fu_load_packet, fu_store_packet
    );

    modport master (
        output in_packet, in_class, squash,
        output alu_avail, mult_avail, load_avail, store_avail,
        input  in_ready, occupancy,
        input  fu_alu_packet, fu_mult_packet, fu_load_packet, fu_store_packet
    );
endinterface

// File: rtl/fu_issue.sv
// Per-class in-order issue queues feeding ALU/MULT/LOAD/STORE units.
// Optional same-cycle bypass for empty queues is enabled by FU_ISSUE_BYPASS_EN.
module fu_issue
    import fu_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    fu_issue_if.slave  io
);
    localparam int unsigned NC      = 4;
    localparam int unsigned NS      = `N;
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int unsigned NU_ALU  = `NUM_FU_ALU;
    localparam int unsigned NU_MULT = `NUM_FU_MULT;
    localparam int unsigned NU_LOAD = `NUM_FU_LOAD;
    localparam int unsigned NU_STOR = `NUM_FU_STORE;
    localparam int unsigned MAX_AM  = (NU_ALU > NU_MULT) ? NU_ALU : NU_MULT;
    localparam int unsigned MAX_LS  = (NU_LOAD > NU_STOR) ? NU_LOAD : NU_STOR;
    localparam int unsigned MAXU    = (MAX_AM > MAX_LS) ? MAX_AM : MAX_LS;

    fu_packet_t       q       [NC][DEPTH];
    logic [PW-1:0]    head    [NC];
    logic [PW-1:0]    tail    [NC];
    logic [CW-1:0]    count   [NC];
    fu_packet_t       out_q   [NC][MAXU];
    fu_packet_t       nxt_out [NC][MAXU];
    logic [MAXU-1:0]  avail_v [NC];
    logic [MAXU-1:0]  free    [NC];
    logic [CW-1:0]    deq     [NC];
    logic [CW-1:0]    enq     [NC];
    logic             wr_en   [NS];
    logic [PW-1:0]    wr_ptr  [NS];
    logic [1:0]       wr_cls  [NS];
    logic             bypassed[NS];
    logic             accept;

    // Accept only when every class can absorb a full packet, so no slot is ever dropped.
    always_comb begin
        accept = 1'b1;
        for (int c = 0; c < NC; c++) begin
            if (count[c] > CW'(DEPTH - NS)) accept = 1'b0;
        end
    end
    assign io.in_ready = accept;

    always_comb begin
        for (int c = 0; c < NC; c++) avail_v[c] = '0;
        avail_v[0][NU_ALU-1:0]  = io.alu_avail;
        avail_v[1][NU_MULT-1:0] = io.mult_avail;
        avail_v[2][NU_LOAD-1:0] = io.load_avail;
        avail_v[3][NU_STOR-1:0] = io.store_avail;
    end

    // Issue oldest entries to free units, optional bypass, then tail enqueue.
    always_comb begin
        for (int c = 0; c < NC; c++) begin
            deq[c]  = '0;
            enq[c]  = '0;
            free[c] = '0;
            for (int u = 0; u < MAXU; u++) nxt_out[c][u] = '0;
        end
        for (int i = 0; i < NS; i++) begin
            wr_en[i]    = 1'b0;
            wr_ptr[i]   = '0;
            wr_cls[i]   = io.in_class[i];
            bypassed[i] = 1'b0;
        end

        for (int c = 0; c < NC; c++) begin
            for (int u = 0; u < MAXU; u++) begin
                if (avail_v[c][u]) begin
                    if (deq[c] < count[c]) begin
                        nxt_out[c][u] = q[c][PW'(head[c] + PW'(deq[c]))];
                        deq[c]        = deq[c] + CW'(1);
                    end else begin
                        free[c][u] = 1'b1;
                    end
                end
            end
        end

`ifdef FU_ISSUE_BYPASS_EN
        for (int i = 0; i < NS; i++) begin
            if (accept && io.in_packet[i].valid && (deq[wr_cls[i]] == count[wr_cls[i]])) begin
                for (int u = 0; u < MAXU; u++) begin
                    if (!bypassed[i] && free[wr_cls[i]][u]) begin
                        nxt_out[wr_cls[i]][u] = io.in_packet[i];
                        free[wr_cls[i]][u]    = 1'b0;
                        bypassed[i]           = 1'b1;
                    end
                end
            end
        end
`endif

        for (int i = 0; i < NS; i++) begin
            if (accept && io.in_packet[i].valid && !bypassed[i]) begin
                wr_en[i]         = 1'b1;
                wr_ptr[i]        = PW'(tail[wr_cls[i]] + PW'(enq[wr_cls[i]]));
                enq[wr_cls[i]]   = enq[wr_cls[i]] + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset || io.squash) begin
            for (int c = 0; c < NC; c++) begin
                head[c]  <= '0;
                tail[c]  <= '0;
                count[c] <= '0;
                for (int u = 0; u < MAXU; u++) out_q[c][u] <= '0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                head[c]  <= PW'(head[c] + PW'(deq[c]));
                tail[c]  <= PW'(tail[c] + PW'(enq[c]));
                count[c] <= count[c] + enq[c] - deq[c];
                for (int u = 0; u < MAXU; u++) out_q[c][u] <= nxt_out[c][u];
            end
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NS; i++) begin
            if (wr_en[i] && !io.squash) q[wr_cls[i]][wr_ptr[i]] <= io.in_packet[i];
        end
    end

    for (genvar c = 0; c < NC; c++) begin : g_occ
        assign io.occupancy[c] = count[c];
    end
    for (genvar u = 0; u < NU_ALU; u++) begin : g_alu
        assign io.fu_alu_packet[u] = out_q[0][u];
    end
    for (genvar u = 0; u < NU_MULT; u++) begin : g_mult
        assign io.fu_mult_packet[u] = out_q[1][u];
    end
    for (genvar u = 0; u < NU_LOAD; u++) begin : g_load
        assign io.fu_load_packet[u] = out_q[2][u];
    end
    for (genvar u = 0; u < NU_STOR; u++) begin : g_store
        assign io.fu_store_packet[u] = out_q[3][u];
    end
endmodule

// File: tb/tb_fu_issue.sv
// Directed bench for fu_issue (default build: N=2, 2 ALU, 1 MULT/LOAD/STORE, DEPTH=4).
module tb_fu_issue;
    import fu_issue_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    fu_issue_if #(.DEPTH(4)) io ();

    fu_issue #(.DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input fu_packet_t p);
        return {23'd0, p.valid, p.tag};
    endfunction

    function automatic logic [31:0] ep(input logic [7:0] t);
        return {23'd0, 1'b1, t};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slot(input int i, input logic v, input logic [1:0] c, input logic [7:0] t);
        io.in_packet[i].valid = v;
        io.in_packet[i].tag   = t;
        io.in_class[i]        = c;
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) set_slot(i, 1'b0, 2'd0, 8'h00);
    endtask

    logic [7:0] mq[$];
    logic [7:0] exp_tag;
    logic       exp_v;
    logic       rdy;
    int         accepted;
    int         issued;
    int         cyc;

    initial begin
        reset          = 1'b0;
        io.squash      = 1'b0;
        io.alu_avail   = '0;
        io.mult_avail  = '0;
        io.load_avail  = '0;
        io.store_avail = '0;
        clr();
        #1;
        chk("rst_occ0", 32'(io.occupancy[0]), 0);
        chk("rst_ready", 32'(io.in_ready), 1);
        // First edge under reset must neither enqueue nor issue.
        set_slot(0, 1'b1, 2'd0, 8'h01);
        set_slot(1, 1'b1, 2'd2, 8'h02);
        io.alu_avail = 2'b11;
        step();
        chk("rst_edge_occ0", 32'(io.occupancy[0]), 0);
        chk("rst_edge_occ2", 32'(io.occupancy[2]), 0);
        chk("rst_edge_alu0", 32'(io.fu_alu_packet[0].valid), 0);
        reset = 1'b1;
        clr();

        // Two ALU slots through an empty queue: visible two edges after accept.
        set_slot(0, 1'b1, 2'd0, 8'h11);
        set_slot(1, 1'b1, 2'd0, 8'h12);
        step();
        clr();
        chk("lat_occ_after_accept", 32'(io.occupancy[0]), 2);
        chk("lat_alu0_early", 32'(io.fu_alu_packet[0].valid), 0);
        step();
        chk("lat_alu0", pk(io.fu_alu_packet[0]), ep(8'h11));
        chk("lat_alu1", pk(io.fu_alu_packet[1]), ep(8'h12));
        chk("lat_occ_drained", 32'(io.occupancy[0]), 0);
        step();
        chk("lat_alu0_one_cycle", 32'(io.fu_alu_packet[0].valid), 0);
        chk("lat_alu1_one_cycle", 32'(io.fu_alu_packet[1].valid), 0);

        // Backpressure: fill ALU to 3 with no units, then drain one per cycle.
        io.alu_avail = 2'b00;
        set_slot(0, 1'b1, 2'd0, 8'h21);
        set_slot(1, 1'b1, 2'd0, 8'h22);
        step();
        chk("bp_occ2", 32'(io.occupancy[0]), 2);
        chk("bp_ready_at2", 32'(io.in_ready), 1);
        set_slot(0, 1'b1, 2'd0, 8'h23);
        set_slot(1, 1'b0, 2'd0, 8'h00);
        step();
        chk("bp_occ3", 32'(io.occupancy[0]), 3);
        chk("bp_ready_at3", 32'(io.in_ready), 0);
        set_slot(0, 1'b1, 2'd0, 8'h2e);
        set_slot(1, 1'b1, 2'd1, 8'h2f);
        step();
        chk("bp_ignored_alu", 32'(io.occupancy[0]), 3);
        chk("bp_ignored_mult", 32'(io.occupancy[1]), 0);
        clr();
        io.alu_avail = 2'b01;
        step();
        chk("bp_issue1", pk(io.fu_alu_packet[0]), ep(8'h21));
        chk("bp_unit1_idle", 32'(io.fu_alu_packet[1].valid), 0);
        chk("bp_occ_after1", 32'(io.occupancy[0]), 2);
        chk("bp_ready_back", 32'(io.in_ready), 1);
        step();
        chk("bp_issue2", pk(io.fu_alu_packet[0]), ep(8'h22));
        step();
        chk("bp_issue3", pk(io.fu_alu_packet[0]), ep(8'h23));
        chk("bp_occ_empty", 32'(io.occupancy[0]), 0);
        step();
        chk("bp_idle", 32'(io.fu_alu_packet[0].valid), 0);

        // STORE full must not stall ALU issue.
        io.alu_avail = 2'b00;
        set_slot(0, 1'b1, 2'd0, 8'h41);
        set_slot(1, 1'b1, 2'd0, 8'h42);
        step();
        set_slot(0, 1'b1, 2'd3, 8'h31);
        set_slot(1, 1'b1, 2'd3, 8'h32);
        step();
        set_slot(0, 1'b1, 2'd3, 8'h33);
        set_slot(1, 1'b1, 2'd3, 8'h34);
        step();
        clr();
        chk("st_full_occ", 32'(io.occupancy[3]), 4);
        chk("st_full_ready", 32'(io.in_ready), 0);
        io.alu_avail = 2'b01;
        step();
        chk("st_alu_issue1", pk(io.fu_alu_packet[0]), ep(8'h41));
        chk("st_still_full", 32'(io.occupancy[3]), 4);
        step();
        chk("st_alu_issue2", pk(io.fu_alu_packet[0]), ep(8'h42));
        chk("st_alu_empty", 32'(io.occupancy[0]), 0);
        io.alu_avail   = 2'b00;
        io.store_avail = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("st_drain", pk(io.fu_store_packet[0]), ep(8'(8'h31 + k)));
        end
        io.store_avail = 1'b0;
        step();
        chk("st_occ_empty", 32'(io.occupancy[3]), 0);

        // Ten MULT ops with alternating availability; order must survive wrap.
        accepted = 0;
        issued   = 0;
        cyc      = 0;
        while ((accepted < 10 || mq.size() != 0) && cyc < 60) begin
            io.mult_avail = (cyc % 2 == 1) ? 1'b1 : 1'b0;
            rdy = (mq.size() <= 2);
            chk("wr_ready", 32'(io.in_ready), 32'(rdy));
            if (accepted < 10) set_slot(0, 1'b1, 2'd1, 8'(8'h70 + accepted));
            else clr();
            exp_v = io.mult_avail[0] && (mq.size() > 0);
            if (exp_v) begin
                exp_tag = mq.pop_front();
                issued++;
            end
            if (accepted < 10 && rdy) begin
                mq.push_back(8'(8'h70 + accepted));
                accepted++;
            end
            step();
            if (exp_v) chk("wr_pkt", pk(io.fu_mult_packet[0]), ep(exp_tag));
            else chk("wr_idle", 32'(io.fu_mult_packet[0].valid), 0);
            chk("wr_occ", 32'(io.occupancy[1]), 32'(mq.size()));
            cyc++;
        end
        clr();
        io.mult_avail = 1'b0;
        chk("wr_in_budget", 32'(cyc < 60), 1);
        chk("wr_issued", 32'(issued), 10);

        // Squash with LOAD occupancy 2, live inputs and free units.
        set_slot(0, 1'b1, 2'd2, 8'h51);
        set_slot(1, 1'b1, 2'd2, 8'h52);
        step();
        chk("sq_load_occ", 32'(io.occupancy[2]), 2);
        set_slot(0, 1'b1, 2'd2, 8'h53);
        set_slot(1, 1'b1, 2'd0, 8'h54);
        io.squash     = 1'b1;
        io.load_avail = 1'b1;
        io.alu_avail  = 2'b11;
        step();
        io.squash = 1'b0;
        clr();
        chk("sq_occ_load", 32'(io.occupancy[2]), 0);
        chk("sq_occ_alu", 32'(io.occupancy[0]), 0);
        chk("sq_no_load", 32'(io.fu_load_packet[0].valid), 0);
        chk("sq_no_alu", 32'(io.fu_alu_packet[0].valid), 0);
        step();
        chk("sq_dropped_load", 32'(io.fu_load_packet[0].valid), 0);
        chk("sq_dropped_alu", 32'(io.fu_alu_packet[0].valid), 0);
        chk("sq_occ_still0", 32'(io.occupancy[2]), 0);
        io.load_avail = 1'b0;

        // Asynchronous reset mid-issue with three ALU entries queued.
        io.alu_avail = 2'b00;
        set_slot(0, 1'b1, 2'd0, 8'h61);
        set_slot(1, 1'b1, 2'd0, 8'h62);
        step();
        set_slot(0, 1'b1, 2'd0, 8'h63);
        set_slot(1, 1'b1, 2'd0, 8'h64);
        io.alu_avail = 2'b01;
        step();
        clr();
        chk("ar_occ3", 32'(io.occupancy[0]), 3);
        chk("ar_issue", pk(io.fu_alu_packet[0]), ep(8'h61));
        #2;
        reset = 1'b0;
        #1;
        chk("ar_occ_cleared", 32'(io.occupancy[0]), 0);
        chk("ar_valid_cleared", 32'(io.fu_alu_packet[0].valid), 0);
        set_slot(0, 1'b1, 2'd0, 8'h65);
        io.alu_avail = 2'b11;
        step();
        chk("ar_hold_occ", 32'(io.occupancy[0]), 0);
        chk("ar_hold_valid", 32'(io.fu_alu_packet[0].valid), 0);
        clr();
        reset = 1'b1;
        #1;
        chk("ar_ready_after", 32'(io.in_ready), 1);
        step();
        chk("ar_discard0", 32'(io.fu_alu_packet[0].valid), 0);
        chk("ar_discard1", 32'(io.fu_alu_packet[1].valid), 0);
        chk("ar_occ_after", 32'(io.occupancy[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
